// File: rtl/gaussian_frame_master.sv
// Frame walker for the gaussianAccel slave: copies border pixels and routes each
// interior pixel's 3x3 neighbourhood through the accelerator, writing the result.
module gaussian_frame_master #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd_en,
  input  logic [31:0]       src_rddata,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_wr_en,
  output logic [31:0]       dst_wrdata,
  output logic [3:0]        acc_addr,
  output logic              acc_wr_en,
  output logic              acc_rd_en,
  output logic [31:0]       acc_writedata,
  input  logic [31:0]       acc_readdata
);

  typedef enum logic [2:0] {IDLE, BRD_RD, BRD_WR, TAP, ACC_RD, ACC_WR, NEXT, FIN} state_t;

  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  state_t              r_state;
  logic [DIM_W-1:0]    r_w, r_h, r_row, r_col;
  logic [ADDR_W-1:0]   r_src_base, r_dst_base, r_row_off;
  logic [3:0]          r_tap;
  logic                r_last, r_from_acc;
  logic                r_busy, r_done;
  logic [ADDR_W-1:0]   r_src_addr, r_dst_addr;
  logic                r_src_rd_en, r_dst_wr_en, r_acc_wr_en, r_acc_rd_en;
  logic [3:0]          r_acc_addr;

  logic [ADDR_W-1:0]   w_wide, w_pix_off;
  logic                w_border, w_col_last, w_row_last;
  logic                w_unused;

  function automatic logic [7:0] sat8(input logic [31:0] x);
    return (x > 32'd255) ? 8'hFF : x[7:0];
  endfunction

  // Offset of tap k (1..9, row-major around the centre) from the centre pixel.
  function automatic logic [ADDR_W-1:0] tap_off(input logic [3:0] k,
                                                input logic [ADDR_W-1:0] w);
    logic [ADDR_W-1:0] row_d;
    logic [ADDR_W-1:0] res;
    case (k)
      4'd1, 4'd2, 4'd3: row_d = -w;
      4'd4, 4'd5, 4'd6: row_d = '0;
      default:          row_d = w;
    endcase
    case (k)
      4'd1, 4'd4, 4'd7: res = row_d - ADDR_W'(1);
      4'd2, 4'd5, 4'd8: res = row_d;
      default:          res = row_d + ADDR_W'(1);
    endcase
    return res;
  endfunction

  assign w_wide     = ADDR_W'(r_w);
  assign w_pix_off  = r_row_off + ADDR_W'(r_col);
  assign w_col_last = (r_col == r_w - ONE_D);
  assign w_row_last = (r_row == r_h - ONE_D);
  assign w_border   = (r_row == '0) || (r_col == '0) || w_row_last || w_col_last;
  assign w_unused   = ^src_rddata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_w         <= '0;
      r_h         <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_src_base  <= '0;
      r_dst_base  <= '0;
      r_row_off   <= '0;
      r_tap       <= '0;
      r_last      <= 1'b0;
      r_from_acc  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_src_addr  <= '0;
      r_dst_addr  <= '0;
      r_src_rd_en <= 1'b0;
      r_dst_wr_en <= 1'b0;
      r_acc_wr_en <= 1'b0;
      r_acc_rd_en <= 1'b0;
      r_acc_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_w        <= img_w;
            r_h        <= img_h;
            r_src_base <= src_base;
            r_dst_base <= dst_base;
            r_row      <= '0;
            r_col      <= '0;
            r_row_off  <= '0;
            r_last     <= 1'b0;
            if (img_w == '0 || img_h == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              // Pixel (0,0) is always border.
              r_busy      <= 1'b1;
              r_state     <= BRD_RD;
              r_src_rd_en <= 1'b1;
              r_src_addr  <= src_base;
            end
          end
        end
        BRD_RD: begin
          r_src_rd_en <= 1'b0;
          r_dst_wr_en <= 1'b1;
          r_dst_addr  <= r_dst_base + w_pix_off;
          r_from_acc  <= 1'b0;
          r_state     <= BRD_WR;
        end
        TAP: begin
          // r_tap is t: read tap t+2 and write tap t+1 on the following cycle.
          if (r_tap == 4'd9) begin
            r_acc_wr_en <= 1'b0;
            r_acc_rd_en <= 1'b1;
            r_acc_addr  <= 4'd0;
            r_state     <= ACC_RD;
          end else begin
            r_acc_wr_en <= 1'b1;
            r_acc_addr  <= r_tap + 4'd1;
            r_src_rd_en <= (r_tap < 4'd8);
            r_src_addr  <= r_src_base + w_pix_off + tap_off(r_tap + 4'd2, w_wide);
            r_tap       <= r_tap + 4'd1;
          end
        end
        ACC_RD: begin
          r_acc_rd_en <= 1'b0;
          r_dst_wr_en <= 1'b1;
          r_dst_addr  <= r_dst_base + w_pix_off;
          r_from_acc  <= 1'b1;
          r_state     <= ACC_WR;
        end
        BRD_WR, ACC_WR: begin
          r_dst_wr_en <= 1'b0;
          r_last      <= w_col_last && w_row_last;
          if (w_col_last) begin
            r_col     <= '0;
            r_row     <= r_row + ONE_D;
            r_row_off <= r_row_off + w_wide;
          end else begin
            r_col     <= r_col + ONE_D;
          end
          r_state <= NEXT;
        end
        NEXT: begin
          // Counters already point at the next pixel here.
          if (r_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else if (w_border) begin
            r_src_rd_en <= 1'b1;
            r_src_addr  <= r_src_base + w_pix_off;
            r_state     <= BRD_RD;
          end else begin
            r_src_rd_en <= 1'b1;
            r_src_addr  <= r_src_base + w_pix_off + tap_off(4'd1, w_wide);
            r_tap       <= 4'd0;
            r_state     <= TAP;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign src_addr      = r_src_addr;
  assign src_rd_en     = r_src_rd_en;
  assign dst_addr      = r_dst_addr;
  assign dst_wr_en     = r_dst_wr_en;
  assign acc_addr      = r_acc_addr;
  assign acc_wr_en     = r_acc_wr_en;
  assign acc_rd_en     = r_acc_rd_en;
  // Read data arrives the cycle after the strobe, so write data is steered combinationally.
  assign dst_wrdata    = !r_dst_wr_en ? 32'd0 :
                         r_from_acc   ? {24'd0, sat8(acc_readdata)} :
                                        {24'd0, src_rddata[7:0]};
  assign acc_writedata = r_acc_wr_en ? {24'd0, src_rddata[7:0]} : 32'd0;

endmodule

// File: tb/tb_gaussian_frame_master.sv
// Bench for gaussian_frame_master: memory and accelerator stubs plus a raster-order frame model.
module tb_gaussian_frame_master;
  localparam int AW = 16;
  localparam int DW = 10;
  localparam int F_SEQ = 0, F_FIFTY = 1, F_255 = 2, F_RND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start;
  logic [DW-1:0] img_w, img_h;
  logic [AW-1:0] src_base, dst_base;
  logic          busy, done, src_rd_en, dst_wr_en, acc_wr_en, acc_rd_en;
  logic [AW-1:0] src_addr, dst_addr;
  logic [31:0]   src_rddata, dst_wrdata, acc_writedata, acc_readdata;
  logic [3:0]    acc_addr;

  gaussian_frame_master #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .img_w(img_w), .img_h(img_h),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
    .src_addr(src_addr), .src_rd_en(src_rd_en), .src_rddata(src_rddata),
    .dst_addr(dst_addr), .dst_wr_en(dst_wr_en), .dst_wrdata(dst_wrdata),
    .acc_addr(acc_addr), .acc_wr_en(acc_wr_en), .acc_rd_en(acc_rd_en),
    .acc_writedata(acc_writedata), .acc_readdata(acc_readdata)
  );

  // Source memory and accelerator stub
  logic [31:0] src_mem [0:65535];
  int          acc_mode;
  int          tap [1:9];

  function automatic int finish_fn(input int mode, input int wsum);
    if (mode == 0) return wsum / 16;
    if (mode == 1) return wsum;
    return 300;
  endfunction

  function automatic int stub_result();
    int s;
    s = tap[1] + 2*tap[2] + tap[3] + 2*tap[4] + 4*tap[5] + 2*tap[6] + tap[7] + 2*tap[8] + tap[9];
    return finish_fn(acc_mode, s);
  endfunction

  always @(posedge clk) begin
    if (src_rd_en) src_rddata <= src_mem[src_addr];
    if (acc_wr_en && acc_addr >= 4'd1 && acc_addr <= 4'd9) tap[acc_addr] <= int'(acc_writedata[7:0]);
    if (acc_rd_en && acc_addr == 4'd0) acc_readdata <= 32'(stub_result());
  end

  // Bus monitor
  logic [47:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic [35:0] accw_q[$];
  int acc_rd_cnt, viol_cnt, bad_rdaddr;

  always @(negedge clk) begin
    int n;
    if (reset_n) begin
      n = int'(src_rd_en) + int'(dst_wr_en) + int'(acc_wr_en) + int'(acc_rd_en);
      if (n > 1 && !(n == 2 && src_rd_en && acc_wr_en)) viol_cnt++;
      if (src_rd_en) rd_q.push_back(src_addr);
      if (dst_wr_en) wr_q.push_back({dst_addr, dst_wrdata});
      if (acc_wr_en) accw_q.push_back({acc_addr, acc_writedata});
      if (acc_rd_en) begin
        acc_rd_cnt++;
        if (acc_addr != 4'd0) bad_rdaddr++;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: walks the frame in raster order straight from the rules.
  logic [47:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [35:0] exp_acc[$];
  int exp_cyc, exp_nrd;

  function automatic logic [15:0] a16(input int base, input int off);
    return 16'(base + off);
  endfunction

  function automatic int pix(input int base, input int off);
    return int'(src_mem[a16(base, off)][7:0]);
  endfunction

  task automatic build_model(input int w, input int h, input int sb, input int db, input int mode);
    int s, k, v, off, p;
    exp_wr.delete(); exp_rd.delete(); exp_acc.delete();
    exp_cyc = 0; exp_nrd = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r == 0 || c == 0 || r == h-1 || c == w-1) begin
          exp_rd.push_back(a16(sb, r*w + c));
          exp_wr.push_back({a16(db, r*w + c), 24'd0, 8'(pix(sb, r*w + c))});
          exp_cyc += 3;
        end else begin
          s = 0; k = 1;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              off = (r+dr)*w + (c+dc);
              p = pix(sb, off);
              exp_rd.push_back(a16(sb, off));
              exp_acc.push_back({4'(k), 32'(p)});
              s += p * (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
              k++;
            end
          end
          v = finish_fn(mode, s);
          if (v > 255) v = 255;
          exp_wr.push_back({a16(db, r*w + c), 32'(v)});
          exp_cyc += 13;
          exp_nrd++;
        end
      end
    end
  endtask

  task automatic fill_src(input int sb, input int w, input int h, input int fmode);
    int p;
    for (int i = 0; i < w*h; i++) begin
      case (fmode)
        F_SEQ:   p = i + 1;
        F_FIFTY: p = (i == 4) ? 50 : i + 1;
        F_255:   p = 255;
        default: p = int'($urandom_range(0, 255));
      endcase
      src_mem[a16(sb, i)] = {24'($urandom), 8'(p)};
    end
  endtask

  task automatic cmp_queues(input string tag);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      if (wr_q[i] !== exp_wr[i] || i == exp_wr.size() - 1) begin
        check({tag, "_wr"}, 64'(wr_q[i]), 64'(exp_wr[i]));
        break;
      end
    end
    check({tag, "_nrd"}, 64'(rd_q.size()), 64'(exp_rd.size()));
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) begin
      if (rd_q[i] !== exp_rd[i] || i == exp_rd.size() - 1) begin
        check({tag, "_rdaddr"}, 64'(rd_q[i]), 64'(exp_rd[i]));
        break;
      end
    end
    check({tag, "_nacc"}, 64'(accw_q.size()), 64'(exp_acc.size()));
    for (int i = 0; i < accw_q.size() && i < exp_acc.size(); i++) begin
      if (accw_q[i] !== exp_acc[i] || i == exp_acc.size() - 1) begin
        check({tag, "_tap"}, 64'(accw_q[i]), 64'(exp_acc[i]));
        break;
      end
    end
    check({tag, "_overlap"}, 64'(viol_cnt), 64'd0);
    check({tag, "_rdaddr0"}, 64'(bad_rdaddr), 64'd0);
  endtask

  task automatic clear_mon();
    wr_q.delete(); rd_q.delete(); accw_q.delete();
    acc_rd_cnt = 0; viol_cnt = 0; bad_rdaddr = 0;
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input int sb, input int db,
                           input int amode, input int cyc_tab, input int reads_tab, input int xstart);
    int n, lat;
    bit got;
    acc_mode = amode;
    build_model(w, h, sb, db, amode);
    clear_mon();
    @(negedge clk);
    img_w = DW'(w); img_h = DW'(h); src_base = AW'(sb); dst_base = AW'(db); start = 1'b1;
    n = 0; got = 1'b0;
    while (n < 3000 && !got) begin
      @(negedge clk);
      n++;
      start = (n == xstart) && (xstart > 0);
      if (n == 1 && w*h > 0) check({tag, "_busy_on"}, 64'(busy), 64'd1);
      if (n == 3) begin
        img_w = img_w ^ DW'(3); img_h = img_h ^ DW'(1); src_base = src_base + 16'd7; dst_base = dst_base + 16'd9;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    lat = n - 1;
    check({tag, "_latency"}, 64'(lat), 64'(cyc_tab >= 0 ? cyc_tab : exp_cyc));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_acc_reads"}, 64'(acc_rd_cnt), 64'(reads_tab >= 0 ? reads_tab : exp_nrd));
    cmp_queues(tag);
  endtask

  typedef struct {
    int w; int h; int sb; int db; int fill; int amode; int cyc; int reads; int xstart;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, dseen;
    int w0;
    tbl[0] = '{3, 3, 100,     200,     F_SEQ,   0, 37,  1,  0};
    tbl[1] = '{3, 3, 0,       50,      F_FIFTY, 0, 37,  1,  0};
    tbl[2] = '{4, 4, 1000,    3000,    F_255,   0, 88,  4,  0};
    tbl[3] = '{2, 5, 10,      40,      F_RND,   0, 30,  0,  0};
    tbl[4] = '{3, 3, 300,     400,     F_SEQ,   2, 37,  1,  15};
    tbl[5] = '{5, 4, 'hFFF0,  'hFFFA,  F_RND,   1, 120, 6,  0};
    tbl[6] = '{1, 1, 20,      30,      F_RND,   0, 3,   0,  0};
    tbl[7] = '{6, 5, 500,     900,     F_RND,   0, 210, 12, 0};
    tbl[8] = '{0, 7, 60,      70,      F_RND,   0, 0,   0,  0};

    reset_n = 1'b0; start = 1'b0; img_w = '0; img_h = '0; src_base = '0; dst_base = '0;
    acc_mode = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({busy, done, src_rd_en, dst_wr_en, acc_wr_en, acc_rd_en, acc_addr}), 64'd0);
    check("reset_addr", 64'({src_addr, dst_addr}), 64'd0);
    check("reset_data", 64'({dst_wrdata, acc_writedata}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      fill_src(tbl[i].sb, tbl[i].w, tbl[i].h, tbl[i].fill);
      run_frame($sformatf("vec%0d", i), tbl[i].w, tbl[i].h, tbl[i].sb, tbl[i].db,
                tbl[i].amode, tbl[i].cyc, tbl[i].reads, tbl[i].xstart);
    end

    // Reset asserted at t=5 of the first interior pixel
    fill_src(100, 3, 3, F_SEQ);
    acc_mode = 0;
    clear_mon();
    @(negedge clk);
    img_w = 10'd3; img_h = 10'd3; src_base = 16'd100; dst_base = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (acc_wr_en && acc_addr == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_reach_t5", 64'(found), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_strobes", 64'({src_rd_en, dst_wr_en, acc_wr_en, acc_rd_en, busy, done}), 64'd0);
    w0 = wr_q.size();
    dseen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    check("rst_no_done", 64'(dseen), 64'd0);
    check("rst_no_writes", 64'(wr_q.size()), 64'(w0));
    reset_n = 1'b1;
    @(negedge clk);
    run_frame("after_rst", 3, 3, 100, 200, 0, 37, 1, 0);

    // Randomized frames against the model
    for (int i = 0; i < 6; i++) begin
      int w, h, sb, db, am;
      w  = int'($urandom_range(1, 9));
      h  = int'($urandom_range(1, 9));
      sb = int'($urandom_range(0, 65535));
      db = int'($urandom_range(0, 65535));
      am = int'($urandom_range(0, 2));
      fill_src(sb, w, h, F_RND);
      run_frame($sformatf("rnd%0d", i), w, h, sb, db, am, -1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
